serial_chunk_adder: RTL and testbench

//   Multi-cycle, parametrised-width adder: sum = a + b + cin, computed CHUNK bits per clock.

---
 rtl/serial_chunk_adder.sv | 129 ++++++++++++
 tb/tb_serial_chunk_adder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_chunk_adder.sv
// rtl/serial_chunk_adder.sv - multi-cycle adder, CHUNK bits per clock, carry held in a flop.
// Define ADD_SUB_EN to add port sub_i (a + ~b + 1 subtract mode).
module serial_chunk_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
`ifdef ADD_SUB_EN
  input  logic             sub_i,
`endif
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  localparam int NCYC = (CHUNK > 0) ? WIDTH / CHUNK : 1;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

  if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_param
    $error("serial_chunk_adder: illegal WIDTH/CHUNK combination");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;
  logic [CHUNK:0]   chunk;
  logic [WIDTH-1:0] res_shift;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

  assign chunk = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};

  // New chunk enters at the top so after NCYC shifts chunk 0 sits in the LSBs.
  if (CHUNK == WIDTH) begin : g_res_full
    assign res_shift = chunk[CHUNK-1:0];
  end else begin : g_res_part
    assign res_shift = {chunk[CHUNK-1:0], res_q[WIDTH-1:CHUNK]};
  end

`ifdef ADD_SUB_EN
  assign b_load     = sub_i ? ~b_i : b_i;
  assign carry_load = sub_i ? 1'b1 : cin_i;
`else
  assign b_load     = b_i;
  assign carry_load = cin_i;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_load;
          carry_d = carry_load;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        carry_d = chunk[CHUNK];
        res_d   = res_shift;
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(NCYC - 1)) state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        sum_d   = res_q;
        cout_d  = carry_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;
  assign sum_o  = sum_q;
  assign cout_o = cout_q;

endmodule

// File: tb/tb_serial_chunk_adder.sv
// tb/tb_serial_chunk_adder.sv - scoreboard bench for serial_chunk_adder, CHUNK = 2, 8 and 1.
// Define ADD_SUB_EN to also exercise the subtract mode.
module tb_serial_chunk_adder;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
`ifdef ADD_SUB_EN
  logic       sub = 1'b0;
`endif
  logic       busy_w [3];
  logic       done_w [3];
  logic [7:0] sum_w  [3];
  logic       cout_w [3];

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   ncyc [3] = '{4, 1, 8};
  int   free [3] = '{0, 0, 0};
  int   st0 = -100;
  int   en0 = -100;
  logic [7:0] msum = '0;
  logic       mcout = 1'b0;
  exp_t sb [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_chunk_adder #(.WIDTH(8), .CHUNK(2)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .a_i(a), .b_i(b), .cin_i(cin),
`ifdef ADD_SUB_EN
    .sub_i(sub),
`endif
    .busy_o(busy_w[0]), .done_o(done_w[0]), .sum_o(sum_w[0]), .cout_o(cout_w[0]));

  serial_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .a_i(a), .b_i(b), .cin_i(cin),
`ifdef ADD_SUB_EN
    .sub_i(sub),
`endif
    .busy_o(busy_w[1]), .done_o(done_w[1]), .sum_o(sum_w[1]), .cout_o(cout_w[1]));

  serial_chunk_adder #(.WIDTH(8), .CHUNK(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .a_i(a), .b_i(b), .cin_i(cin),
`ifdef ADD_SUB_EN
    .sub_i(sub),
`endif
    .busy_o(busy_w[2]), .done_o(done_w[2]), .sum_o(sum_w[2]), .cout_o(cout_w[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Done must appear exactly on the modelled cycle; sum/cout of the main DUT must hold otherwise.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        if (sb[k].size() > 0 && sb[k][0].cyc == cyc) begin
          check($sformatf("done[%0d]", k), 32'(done_w[k]), 32'd1);
          e = sb[k].pop_front();
          check($sformatf("sum[%0d]", k), 32'(sum_w[k]), 32'(e.sum));
          check($sformatf("cout[%0d]", k), 32'(cout_w[k]), 32'(e.cout));
          if (k == 0) begin
            msum  = e.sum;
            mcout = e.cout;
          end
        end else begin
          check($sformatf("no_done[%0d]", k), 32'(done_w[k]), 32'd0);
        end
      end
      check("busy[0]", 32'(busy_w[0]), 32'(cyc >= st0 && cyc <= en0));
      check("sum_hold[0]", 32'(sum_w[0]), 32'(msum));
      check("cout_hold[0]", 32'(cout_w[0]), 32'(mcout));
    end
  end

  task automatic issue(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
    int t;
    exp_t e;
    logic [8:0] full;
    @(negedge clk);
    a = ta;
    b = tb;
    cin = tc;
    start = 1'b1;
    t = cyc + 1;
    full = {1'b0, ta} + {1'b0, tb} + {8'd0, tc};
`ifdef ADD_SUB_EN
    if (sub) full = {1'b0, ta} + {1'b0, ~tb} + 9'd1;
`endif
    for (int k = 0; k < 3; k++) begin
      if (t >= free[k]) begin
        e.sum  = full[7:0];
        e.cout = full[8];
        e.cyc  = t + ncyc[k] + 1;
        sb[k].push_back(e);
        free[k] = t + ncyc[k] + 2;
        if (k == 0) begin
          st0 = t;
          en0 = t + ncyc[0];
        end
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    cin = 1'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb[0].size() + sb[1].size() + sb[2].size()) > 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("drain", 32'(sb[0].size() + sb[1].size() + sb[2].size()), 32'd0);
    for (int k = 0; k < 3; k++) sb[k].delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #1;
    check("rst_busy", 32'(busy_w[0]), 32'd0);
    check("rst_done", 32'(done_w[0]), 32'd0);
    check("rst_sum", 32'(sum_w[0]), 32'd0);
    check("rst_cout", 32'(cout_w[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // basic add and carry ripple
    issue(8'd3, 8'd4, 1'b0);
    drain();
    issue(8'd200, 8'd100, 1'b1);
    drain();
    issue(8'd255, 8'd0, 1'b1);
    drain();
    issue(8'd255, 8'd255, 1'b1);
    drain();

    // start while busy: during RUN and during DONE of the main DUT
    issue(8'd5, 8'd6, 1'b0);
    issue(8'd1, 8'd1, 1'b0);
    repeat (3) @(posedge clk);
    issue(8'd1, 8'd1, 1'b0);
    drain();
    issue(8'd2, 8'd3, 1'b0);
    drain();

    // asynchronous reset mid-operation
    issue(8'd9, 8'd9, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sb[k].delete();
      free[k] = 0;
    end
    st0 = -100;
    en0 = -100;
    msum = '0;
    mcout = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy_w[0]), 32'd0);
    check("mid_rst_done", 32'(done_w[0]), 32'd0);
    check("mid_rst_sum", 32'(sum_w[0]), 32'd0);
    check("mid_rst_cout", 32'(cout_w[0]), 32'd0);
    check("mid_rst_busy1", 32'(busy_w[2]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    issue(8'd7, 8'd8, 1'b0);
    drain();

    // random operands across all three chunk sizes
    for (int i = 0; i < 10; i++) begin
      issue(8'($urandom), 8'($urandom), 1'($urandom));
      drain();
    end

`ifdef ADD_SUB_EN
    sub = 1'b1;
    issue(8'd5, 8'd6, 1'b0);
    drain();
    issue(8'd9, 8'd4, 1'b1);
    drain();
    sub = 1'b0;
    issue(8'd3, 8'd4, 1'b0);
    drain();
`endif

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
